// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one digit per slot with leading dead time,
// a double-buffered frame loaded over valid/ready, and per-digit blinking.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned DEAD_CYC     = 1000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5*NUM_DIGITS-1:0] frame_in,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic [4:0]              code_out,
    output logic                    frame_tick
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BlkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CntW-1:0] CntLast  = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] DeadLast = CntW'(DEAD_CYC - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);
    localparam logic [BlkW-1:0] BlkLast  = BlkW'(BLINK_FRAMES - 1);
    localparam logic [4:0]      Blank    = 5'h1F;

    typedef enum logic [0:0] {StBlank, StShow} slot_e;

    slot_e                 slot_q, slot_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [4:0]            active_q [NUM_DIGITS];
    logic [4:0]            active_d [NUM_DIGITS];
    logic [4:0]            shadow_q [NUM_DIGITS];
    logic [4:0]            shadow_d [NUM_DIGITS];
    logic                  pending_q, pending_d;
    logic [BlkW-1:0]       blk_cnt_q, blk_cnt_d;
    logic                  blk_phase_q, blk_phase_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic [4:0]            code_q, code_d;
    logic                  tick_q, tick_d;
    logic                  ready_q, ready_d;

    logic slot_end;
    logic boundary;
    logic accept;

    assign slot_end = (cnt_q == CntLast);
    assign boundary = slot_end && (idx_q == IdxLast);
    assign accept   = frame_valid && ready_q;

    // Slot counter, digit index and the BLANK/SHOW phase within a slot.
    always_comb begin
        cnt_d  = cnt_q + CntW'(1);
        idx_d  = idx_q;
        slot_d = slot_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
        end
        unique case (slot_q)
            StBlank: if (cnt_q == DeadLast) slot_d = StShow;
            StShow:  if (slot_end) slot_d = StBlank;
            default: slot_d = StBlank;
        endcase
    end

    // Frame buffers: swap on the boundary first, so an accept on that same edge
    // lands in the shadow and waits for the next boundary.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (accept) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_d[i] = frame_in[5*i +: 5];
            end
            pending_d = 1'b1;
        end
    end

    always_comb begin
        blk_cnt_d   = blk_cnt_q;
        blk_phase_d = blk_phase_q;
        if (boundary) begin
            if (blk_cnt_q == BlkLast) begin
                blk_cnt_d   = '0;
                blk_phase_d = ~blk_phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BlkW'(1);
            end
        end
    end

    // Outputs are registered, so they are computed from the next-state values.
    always_comb begin
        tick_d     = boundary;
        ready_d    = ~pending_d;
        code_d     = active_d[idx_d];
        digit_en_d = '0;
        if (slot_d == StShow) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if ((idx_d == IdxW'(i)) && !(blk_phase_d && blink_mask[i])) begin
                    digit_en_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= StBlank;
            cnt_q       <= '0;
            idx_q       <= '0;
            active_q    <= '{default: Blank};
            shadow_q    <= '{default: Blank};
            pending_q   <= 1'b0;
            blk_cnt_q   <= '0;
            blk_phase_q <= 1'b0;
            digit_en_q  <= '0;
            code_q      <= Blank;
            tick_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            active_q    <= active_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            blk_cnt_q   <= blk_cnt_d;
            blk_phase_q <= blk_phase_d;
            digit_en_q  <= digit_en_d;
            code_q      <= code_d;
            tick_q      <= tick_d;
            ready_q     <= ready_d;
        end
    end

    assign digit_en    = digit_en_q;
    assign code_out    = code_q;
    assign frame_tick  = tick_q;
    assign frame_ready = ready_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: reset table, hand-written handshake/blink/reset sequences and a
// randomized run, all checked against a cycle-count based reference model.
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int S     = 8;
    localparam int D     = 2;
    localparam int BF    = 2;
    localparam int FRAME = N * S;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5*N-1:0] frame_in = '0;
    logic          frame_valid = 1'b0;
    logic          frame_ready;
    logic [N-1:0]  blink_mask = '0;
    logic [N-1:0]  digit_en;
    logic [4:0]    code_out;
    logic          frame_tick;

    seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .SCAN_DIV    (S),
        .DEAD_CYC    (D),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_in   (frame_in),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .blink_mask (blink_mask),
        .digit_en   (digit_en),
        .code_out   (code_out),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: k counts edges since reset release (k=0 is the reset-held cycle).
    int         k = 0;
    logic [4:0] m_act [N];
    logic [4:0] m_sh  [N];
    logic       m_pend = 1'b0;
    logic [N-1:0] m_mask = '0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at k=%0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    function automatic logic exp_ready();
        return (k == 0) ? 1'b0 : !m_pend;
    endfunction

    function automatic logic [N-1:0] exp_en();
        int c     = k % S;
        int idx   = (k / S) % N;
        int phase = (k / FRAME / BF) % 2;
        if (c < D) return '0;
        if (phase == 1 && m_mask[idx]) return '0;
        return N'(1 << idx);
    endfunction

    function automatic logic [4:0] exp_code();
        return m_act[(k / S) % N];
    endfunction

    function automatic logic exp_tick();
        return (k != 0) && (k % FRAME == 0);
    endfunction

    task automatic model_edge();
        logic acc;
        if (rst) begin
            k      = 0;
            m_pend = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_act[i] = 5'h1F;
                m_sh[i]  = 5'h1F;
            end
        end else begin
            acc = frame_valid && exp_ready();
            if ((k % FRAME == FRAME - 1) && m_pend) begin
                m_act  = m_sh;
                m_pend = 1'b0;
            end
            if (acc) begin
                for (int i = 0; i < N; i++) m_sh[i] = frame_in[5*i +: 5];
                m_pend = 1'b1;
            end
            k++;
        end
        m_mask = blink_mask;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("digit_en", 32'(digit_en), 32'(exp_en()));
        check("code_out", 32'(code_out), 32'(exp_code()));
        check("frame_ready", 32'(frame_ready), 32'(exp_ready()));
        check("frame_tick", 32'(frame_tick), 32'(exp_tick()));
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (k < target && guard < 5000) begin
            step();
            guard++;
        end
        check("run_to_reached", 32'(k), 32'(target));
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        frame_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic         r;
        logic [N-1:0] en;
        logic [4:0]   code;
        logic         rdy;
        logic         tk;
    } vec_t;

    vec_t tbl [12];

    localparam logic [5*N-1:0] FrameA = {5'h3, 5'h2, 5'h1, 5'h0};
    localparam logic [5*N-1:0] FrameB = {5'h7, 5'h6, 5'h5, 5'h4};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;

        tbl[0]  = '{1'b1, 4'b0000, 5'h1F, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'b0000, 5'h1F, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'b0000, 5'h1F, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'b0001, 5'h1F, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 4'b0001, 5'h1F, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 4'b0001, 5'h1F, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'b0001, 5'h1F, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 4'b0001, 5'h1F, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 4'b0001, 5'h1F, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 4'b0000, 5'h1F, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'b0000, 5'h1F, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'b0010, 5'h1F, 1'b1, 1'b0};

        // Reset and the first slots after release.
        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].r;
            step();
            check("tbl_digit_en", 32'(digit_en), 32'(tbl[i].en));
            check("tbl_code_out", 32'(code_out), 32'(tbl[i].code));
            check("tbl_frame_ready", 32'(frame_ready), 32'(tbl[i].rdy));
            check("tbl_frame_tick", 32'(frame_tick), 32'(tbl[i].tk));
        end
        run_to(18);
        check("t1_digit2", 32'(digit_en), 32'(4'b0100));
        run_to(26);
        check("t1_digit3", 32'(digit_en), 32'(4'b1000));
        check("t1_blank_code", 32'(code_out), 32'(5'h1F));

        // Load during frame 0, shown from frame 1.
        do_reset();
        frame_in    = FrameA;
        frame_valid = 1'b1;
        step();
        step();
        frame_valid = 1'b0;
        check("t2_ready_busy", 32'(frame_ready), 32'(1'b0));
        run_to(31);
        check("t2_ready_before_bnd", 32'(frame_ready), 32'(1'b0));
        step();
        check("t2_tick", 32'(frame_tick), 32'(1'b1));
        check("t2_ready_after_bnd", 32'(frame_ready), 32'(1'b1));
        check("t2_code0", 32'(code_out), 32'(5'h0));
        run_to(39);
        check("t2_code0_hold", 32'(code_out), 32'(5'h0));
        step();
        check("t2_code1", 32'(code_out), 32'(5'h1));
        run_to(48);
        check("t2_code2", 32'(code_out), 32'(5'h2));
        run_to(56);
        check("t2_code3", 32'(code_out), 32'(5'h3));

        // Second frame held valid while pending.
        do_reset();
        frame_in    = FrameA;
        frame_valid = 1'b1;
        step();
        step();
        frame_in = FrameB;
        run_to(32);
        check("t3_codeA0", 32'(code_out), 32'(5'h0));
        check("t3_ready", 32'(frame_ready), 32'(1'b1));
        step();
        check("t3_acceptB", 32'(frame_ready), 32'(1'b0));
        frame_valid = 1'b0;
        run_to(40);
        check("t3_codeA1", 32'(code_out), 32'(5'h1));
        run_to(64);
        check("t3_codeB0", 32'(code_out), 32'(5'h4));
        check("t3_ready_free", 32'(frame_ready), 32'(1'b1));
        run_to(72);
        check("t3_codeB1", 32'(code_out), 32'(5'h5));

        // Blink digit 1.
        do_reset();
        blink_mask  = 4'b0010;
        frame_in    = FrameA;
        frame_valid = 1'b1;
        step();
        step();
        frame_valid = 1'b0;
        for (int f = 0; f < 5; f++) begin
            run_to(f * FRAME + 10);
            check("t4_en_early", 32'(digit_en), ((f / 2) % 2 == 1) ? 32'h0 : 32'h2);
            check("t4_code", 32'(code_out), (f == 0) ? 32'h1F : 32'h1);
            run_to(f * FRAME + 15);
            check("t4_en_late", 32'(digit_en), ((f / 2) % 2 == 1) ? 32'h0 : 32'h2);
        end
        blink_mask = '0;

        // Reset mid-frame with a pending frame.
        do_reset();
        frame_in    = FrameA;
        frame_valid = 1'b1;
        step();
        step();
        frame_valid = 1'b0;
        run_to(32);
        frame_in    = FrameB;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        check("t5_pending", 32'(frame_ready), 32'(1'b0));
        run_to(53);
        rst = 1'b1;
        step();
        check("t5_rst_en", 32'(digit_en), 32'(4'b0000));
        check("t5_rst_code", 32'(code_out), 32'(5'h1F));
        check("t5_rst_ready", 32'(frame_ready), 32'(1'b0));
        rst = 1'b0;
        step();
        check("t5_ready_after", 32'(frame_ready), 32'(1'b1));
        step();
        check("t5_restart_idx0", 32'(digit_en), 32'(4'b0001));
        run_to(32);
        check("t5_code_gone", 32'(code_out), 32'(5'h1F));
        check("t5_tick", 32'(frame_tick), 32'(1'b1));
        run_to(72);
        check("t5_code_gone2", 32'(code_out), 32'(5'h1F));

        // Free-run ten frames.
        do_reset();
        ticks = 0;
        for (int i = 0; i < 10 * FRAME; i++) begin
            step();
            if (frame_tick === 1'b1) begin
                ticks++;
                check("t6_tick_pos", 32'(k % FRAME), 32'h0);
            end
        end
        check("t6_tick_count", 32'(ticks), 32'd10);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 499) == 0);
            frame_valid = ($urandom_range(0, 3) == 0);
            frame_in    = (5*N)'($urandom);
            blink_mask  = N'($urandom);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
